fp_mult_prenorm: RTL and testbench

- Two-stage pipelined front end of the single-precision FP multiplier.
- Unpacks two IEEE-754 binary32 operands and classifies them. Forms the 48-bit significand product, normalises it to 24 bits, and derives guard/sticky, sign and the unbiased-sum exponent.
- Feeds the rounding stage directly: mant_out, guard_out, sticky_out and sign_out drive its mantissa, guard, sticky and sign inputs.
- Uses a valid/ready handshake on both sides so the multiplier can stall.

---
 rtl/fp_mult_prenorm_pkg.sv | 43 ++++
 rtl/fp_classify.sv | 31 +++
 rtl/fp_mult_prenorm.sv | 155 +++++++++++++++
 tb/tb_fp_mult_prenorm.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_prenorm_pkg.sv
// Shared types and constants for the single-precision multiplier datapath.
package fp_mult_prenorm_pkg;

  // Rounding modes consumed by the downstream rounding stage.
  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } fp_rmode_t;

  // Operand / result class.
  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_NORMAL = 2'd1,
    CLS_INF    = 2'd2,
    CLS_NAN    = 2'd3
  } fp_class_t;

  localparam int         FP_BIAS    = 127;
  localparam logic [7:0] FP_EXP_MAX = 8'd255;
  localparam int         FP_FRAC_W  = 23;

  // Product class: NaN (incl. inf*zero) beats inf, inf beats zero.
  function automatic fp_class_t fp_mul_class(input fp_class_t ca, input fp_class_t cb);
    fp_class_t r;
    if ((ca == CLS_NAN) || (cb == CLS_NAN)) begin
      r = CLS_NAN;
    end else if (((ca == CLS_INF) && (cb == CLS_ZERO)) ||
                 ((ca == CLS_ZERO) && (cb == CLS_INF))) begin
      r = CLS_NAN;
    end else if ((ca == CLS_INF) || (cb == CLS_INF)) begin
      r = CLS_INF;
    end else if ((ca == CLS_ZERO) || (cb == CLS_ZERO)) begin
      r = CLS_ZERO;
    end else begin
      r = CLS_NORMAL;
    end
    return r;
  endfunction

endpackage

// File: rtl/fp_classify.sv
// Unpacks one binary32 value and classifies it; subnormals count as zero.
module fp_classify
  import fp_mult_prenorm_pkg::*;
(
  input  logic [31:0]          x_in,
  output logic                 sign_o,
  output logic [7:0]           exp_o,
  output logic [FP_FRAC_W-1:0] frac_o,
  output fp_class_t            cls_o
);

  // Field split and class decode.
  always_comb begin
    sign_o = x_in[31];
    exp_o  = x_in[30:23];
    frac_o = x_in[FP_FRAC_W-1:0];
    cls_o  = CLS_NORMAL;
    if (x_in[30:23] == 8'd0) begin
      cls_o = CLS_ZERO;
    end else if (x_in[30:23] == FP_EXP_MAX) begin
      if (x_in[FP_FRAC_W-1:0] == {FP_FRAC_W{1'b0}}) begin
        cls_o = CLS_INF;
      end else begin
        cls_o = CLS_NAN;
      end
    end else begin
      cls_o = CLS_NORMAL;
    end
  end

endmodule

// File: rtl/fp_mult_prenorm.sv
// Two-stage multiplier front end: unpack/classify/multiply, then normalise.
module fp_mult_prenorm
  import fp_mult_prenorm_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int BIAS  = FP_BIAS
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [31:0]             a_in,
  input  logic [31:0]             b_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [23:0]             mant_out,
  output logic                    guard_out,
  output logic                    sticky_out,
  output logic                    sign_out,
  output logic signed [EXP_W-1:0] exp_out,
  output fp_class_t               class_out
);

  logic                 sa, sb;
  logic [7:0]           ea, eb;
  logic [FP_FRAC_W-1:0] fa, fb;
  fp_class_t            ca, cb;

  logic s1_load, s2_load, accept;

  logic             s1_valid_q, s1_valid_d;
  logic [47:0]      s1_prod_q, s1_prod_d;
  logic [EXP_W-1:0] s1_esum_q, s1_esum_d;
  logic             s1_sign_q, s1_sign_d;
  fp_class_t        s1_class_q, s1_class_d;

  logic             out_valid_q, out_valid_d;
  logic [23:0]      mant_q, mant_d;
  logic             guard_q, guard_d;
  logic             sticky_q, sticky_d;
  logic             sign_q, sign_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  fp_class_t        class_q, class_d;

  fp_classify u_cls_a (.x_in(a_in), .sign_o(sa), .exp_o(ea), .frac_o(fa), .cls_o(ca));
  fp_classify u_cls_b (.x_in(b_in), .sign_o(sb), .exp_o(eb), .frac_o(fb), .cls_o(cb));

  // Handshake: a stage refills when it is empty or its contents move on.
  always_comb begin
    s2_load  = !out_valid_q || out_ready;
    s1_load  = !s1_valid_q || s2_load;
    in_ready = s1_load;
    accept   = in_valid && s1_load;
  end

  // Stage 1 next state: product, unbiased-sum exponent, sign and class.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_prod_d  = s1_prod_q;
    s1_esum_d  = s1_esum_q;
    s1_sign_d  = s1_sign_q;
    s1_class_d = s1_class_q;
    if (s1_load) begin
      s1_valid_d = accept;
    end else begin
      s1_valid_d = s1_valid_q;
    end
    if (accept) begin
      s1_prod_d  = 48'({1'b1, fa}) * 48'({1'b1, fb});
      s1_esum_d  = EXP_W'(ea) + EXP_W'(eb) - EXP_W'(BIAS);
      s1_sign_d  = sa ^ sb;
      s1_class_d = fp_mul_class(ca, cb);
    end else begin
      s1_prod_d  = s1_prod_q;
    end
  end

  // Stage 2 next state: normalise the product to 24 bits with guard/sticky.
  always_comb begin
    out_valid_d = out_valid_q;
    mant_d      = mant_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    class_d     = class_q;
    if (s2_load) begin
      out_valid_d = s1_valid_q;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (s2_load && s1_valid_q) begin
      sign_d  = s1_sign_q;
      class_d = s1_class_q;
      if (s1_class_q != CLS_NORMAL) begin
        mant_d   = 24'd0;
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        exp_d    = {EXP_W{1'b0}};
      end else if (s1_prod_q[47]) begin
        mant_d   = s1_prod_q[47:24];
        guard_d  = s1_prod_q[23];
        sticky_d = |s1_prod_q[22:0];
        exp_d    = s1_esum_q + EXP_W'(1);
      end else begin
        mant_d   = s1_prod_q[46:23];
        guard_d  = s1_prod_q[22];
        sticky_d = |s1_prod_q[21:0];
        exp_d    = s1_esum_q;
      end
    end else begin
      mant_d = mant_q;
    end
  end

  // Pipeline registers; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= 48'd0;
      s1_esum_q   <= {EXP_W{1'b0}};
      s1_sign_q   <= 1'b0;
      s1_class_q  <= CLS_ZERO;
      out_valid_q <= 1'b0;
      mant_q      <= 24'd0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      exp_q       <= {EXP_W{1'b0}};
      class_q     <= CLS_ZERO;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_esum_q   <= s1_esum_d;
      s1_sign_q   <= s1_sign_d;
      s1_class_q  <= s1_class_d;
      out_valid_q <= out_valid_d;
      mant_q      <= mant_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      class_q     <= class_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign mant_out   = mant_q;
  assign guard_out  = guard_q;
  assign sticky_out = sticky_q;
  assign sign_out   = sign_q;
  assign exp_out    = exp_q;
  assign class_out  = class_q;

endmodule

// File: tb/tb_fp_mult_prenorm.sv
// Directed self-checking bench for fp_mult_prenorm.
module tb_fp_mult_prenorm;
  import fp_mult_prenorm_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        a_in;
  logic [31:0]        b_in;
  logic               out_valid;
  logic               out_ready;
  logic [23:0]        mant_out;
  logic               guard_out;
  logic               sticky_out;
  logic               sign_out;
  logic signed [9:0]  exp_out;
  fp_class_t          class_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mult_prenorm #(.EXP_W(10), .BIAS(127)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .mant_out(mant_out), .guard_out(guard_out), .sticky_out(sticky_out),
    .sign_out(sign_out), .exp_out(exp_out), .class_out(class_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one pair, wait (bounded) for the result; lat = edges until out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, output int lat);
    out_ready = 1'b1;
    a_in = a;
    b_in = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_hs: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (mant_out !== 24'd0 || guard_out !== 1'b0 || sticky_out !== 1'b0 ||
        sign_out !== 1'b0 || exp_out !== 10'sd0 || class_out !== CLS_ZERO) begin
      n_fail++; $display("FAIL reset_data: mant=%h g=%b s=%b sg=%b exp=%0d cls=%0d want all 0",
                         mant_out, guard_out, sticky_out, sign_out, exp_out, class_out);
    end
  endtask

  task automatic test_normal();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [23:0] em [3];
    logic        eg [3];
    logic        est [3];
    logic        esg [3];
    int          ee [3];
    int          lat;
    va[0] = 32'h3FC00000; vb[0] = 32'h3FC00000; em[0] = 24'h900000; eg[0] = 1'b0; est[0] = 1'b0; esg[0] = 1'b0; ee[0] = 128;
    va[1] = 32'hC0000000; vb[1] = 32'h40400000; em[1] = 24'hC00000; eg[1] = 1'b0; est[1] = 1'b0; esg[1] = 1'b1; ee[1] = 129;
    va[2] = 32'h3F800001; vb[2] = 32'h3F800001; em[2] = 24'h800002; eg[2] = 1'b0; est[2] = 1'b1; esg[2] = 1'b0; ee[2] = 127;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], lat);
      n_checks++;
      if (out_valid !== 1'b1 || lat != 2) begin
        n_fail++; $display("FAIL normal%0d_latency: out_valid=%b lat=%0d want 1/2", i, out_valid, lat);
      end
      n_checks++;
      if (mant_out !== em[i] || guard_out !== eg[i] || sticky_out !== est[i]) begin
        n_fail++; $display("FAIL normal%0d_mant: mant=%h g=%b s=%b want %h/%b/%b",
                           i, mant_out, guard_out, sticky_out, em[i], eg[i], est[i]);
      end
      n_checks++;
      if (int'(exp_out) != ee[i] || sign_out !== esg[i] || class_out !== CLS_NORMAL) begin
        n_fail++; $display("FAIL normal%0d_exp: exp=%0d sign=%b cls=%0d want %0d/%b/1",
                           i, exp_out, sign_out, class_out, ee[i], esg[i]);
      end
    end
  endtask

  task automatic test_special();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    fp_class_t   ec [3];
    logic        esg [3];
    int          lat;
    va[0] = 32'h7F800000; vb[0] = 32'h00000000; ec[0] = CLS_NAN;  esg[0] = 1'b0;
    va[1] = 32'hFF800000; vb[1] = 32'h3F800000; ec[1] = CLS_INF;  esg[1] = 1'b1;
    va[2] = 32'h00000001; vb[2] = 32'h3F800000; ec[2] = CLS_ZERO; esg[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], lat);
      n_checks++;
      if (out_valid !== 1'b1 || class_out !== ec[i] || sign_out !== esg[i]) begin
        n_fail++; $display("FAIL special%0d_class: v=%b cls=%0d sign=%b want 1/%0d/%b",
                           i, out_valid, class_out, sign_out, ec[i], esg[i]);
      end
      n_checks++;
      if (mant_out !== 24'd0 || guard_out !== 1'b0 || sticky_out !== 1'b0 || exp_out !== 10'sd0) begin
        n_fail++; $display("FAIL special%0d_zeroed: mant=%h g=%b s=%b exp=%0d want 0",
                           i, mant_out, guard_out, sticky_out, exp_out);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [23:0] em [4];
    logic        esg [4];
    int          ee [4];
    int          sent = 0;
    int          recv = 0;
    logic [23:0] snap_m;
    logic [9:0]  snap_e;
    va[0] = 32'h3FC00000; vb[0] = 32'h3FC00000; em[0] = 24'h900000; esg[0] = 1'b0; ee[0] = 128;
    va[1] = 32'hC0000000; vb[1] = 32'h40400000; em[1] = 24'hC00000; esg[1] = 1'b1; ee[1] = 129;
    va[2] = 32'h3F800001; vb[2] = 32'h3F800001; em[2] = 24'h800002; esg[2] = 1'b0; ee[2] = 127;
    va[3] = 32'h3F800000; vb[3] = 32'h40000000; em[3] = 24'h800000; esg[3] = 1'b0; ee[3] = 128;
    snap_m = 24'd0;
    snap_e = 10'd0;
    for (int cyc = 0; cyc < 30 && recv < 4; cyc++) begin
      in_valid  = (sent < 4);
      a_in      = va[sent % 4];
      b_in      = vb[sent % 4];
      out_ready = !(cyc >= 3 && cyc <= 5);
      #1;
      if (cyc >= 3 && cyc <= 5) begin
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL b2b_stall_c%0d: in_ready=%b out_valid=%b want 0/1", cyc, in_ready, out_valid);
        end
      end
      if (cyc == 3) begin
        snap_m = mant_out;
        snap_e = exp_out;
      end
      if (cyc == 4 || cyc == 5) begin
        n_checks++;
        if (mant_out !== snap_m || exp_out !== snap_e) begin
          n_fail++; $display("FAIL b2b_stable_c%0d: mant=%h exp=%0d want %h/%0d", cyc, mant_out, exp_out, snap_m, snap_e);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (mant_out !== em[recv] || int'(exp_out) != ee[recv] || sign_out !== esg[recv] ||
            class_out !== CLS_NORMAL) begin
          n_fail++; $display("FAIL b2b_result%0d: mant=%h exp=%0d sign=%b cls=%0d want %h/%0d/%b/1",
                             recv, mant_out, exp_out, sign_out, class_out, em[recv], ee[recv], esg[recv]);
        end
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n_checks++;
    if (recv != 4 || sent != 4) begin
      n_fail++; $display("FAIL b2b_count: sent=%0d recv=%0d want 4/4", sent, recv);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    out_ready = 1'b0;
    a_in = 32'h40000000;
    b_in = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_full: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_release: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    issue(32'h3FC00000, 32'h3FC00000, lat);
    n_checks++;
    if (out_valid !== 1'b1 || lat != 2 || mant_out !== 24'h900000 || exp_out !== 10'sd128 ||
        class_out !== CLS_NORMAL) begin
      n_fail++; $display("FAIL rstmid_after: v=%b lat=%0d mant=%h exp=%0d cls=%0d want 1/2/900000/128/1",
                         out_valid, lat, mant_out, exp_out, class_out);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = 32'd0;
    b_in      = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_normal();
    test_special();
    @(posedge clk); #1;
    test_back_to_back();
    @(posedge clk); #1;
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
